trakball_quad_ctrl: RTL and testbench

Trackball step scheduler between the HPS PS/2 mouse packet stream and the game's 4-bit trackball input. It accumulates signed mouse deltas per axis into saturating counters and drains them as quadrature-style direction/clock toggles at a fixed, programmable step rate. It honours cabinet flip and the CPU pause, and sits in the `emu` top level in `clk_sys`, feeding `trakball_i`.

---
 rtl/trakball_pkg.sv | 27 ++
 rtl/trakball_axis.sv | 70 +++++++
 rtl/trakball_quad_ctrl.sv | 119 +++++++++++
 tb/tb_trakball_quad_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trakball_pkg.sv
// Shared types, trakdata bit positions and the clamp helper for the trackball step scheduler.
package trakball_pkg;

   typedef enum logic [1:0] {INIT, RUN, HOLD} trak_state_t;

   localparam int TD_XDIR   = 3;
   localparam int TD_XCLK   = 2;
   localparam int TD_YDIR   = 1;
   localparam int TD_YCLK   = 0;
   localparam int ACC_W_DEF = 12;

   // One PS/2 delta after optional negation: -256 flipped needs a tenth bit
   typedef logic signed [9:0] delta_t;

   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [31:0] s;
      logic signed [31:0] lim;
      s   = a + b;
      lim = (32'sd1 <<< (w - 1)) - 32'sd1;
      if (s > lim)       s = lim;
      else if (s < -lim) s = -lim;
      return s;
   endfunction

endpackage

// File: rtl/trakball_axis.sv
// One trackball axis: saturating delta accumulator drained one step per tick into dir/clk.
// Joystick step injection is built only with TRAKBALL_JOY_EN.
module trakball_axis
   import trakball_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   tick,
   input  logic   dv,
   input  delta_t delta,
`ifdef TRAKBALL_JOY_EN
   input  logic   joy_vld,
   input  logic   joy_dir,
`endif
   output logic   dir,
   output logic   sclk,
   output logic   nz_next,
   output logic   sat
);
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [ACC_W+1:0] wide_t;

   acc_t  acc_q, acc_d;
   logic  dir_q, dir_d, sclk_q, sclk_d;
   logic  step;
   wide_t stepped, dext, raw;

   always_comb begin
      step    = tick && (acc_q != '0);
      stepped = wide_t'(acc_q);
      if (step) stepped = acc_q[ACC_W-1] ? stepped + wide_t'(1) : stepped - wide_t'(1);
      dext    = dv ? wide_t'(delta) : '0;
      raw     = stepped + dext;
      acc_d   = acc_t'(sat_add(32'(stepped), 32'(dext), ACC_W));
      sat     = (wide_t'(acc_d) != raw);
      nz_next = (acc_d != '0);

      dir_d  = dir_q;
      sclk_d = sclk_q;
      if (step) begin
         dir_d  = ~acc_q[ACC_W-1];
         sclk_d = ~sclk_q;
      end
`ifdef TRAKBALL_JOY_EN
      // Joystick only steps an idle axis and leaves the accumulator alone
      else if (tick && joy_vld) begin
         dir_d  = joy_dir;
         sclk_d = ~sclk_q;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         dir_q  <= 1'b0;
         sclk_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         dir_q  <= dir_d;
         sclk_q <= sclk_d;
      end
   end

   assign dir  = dir_q;
   assign sclk = sclk_q;

endmodule

// File: rtl/trakball_quad_ctrl.sv
// Trackball step scheduler: PS/2 mouse packets -> per-axis quadrature dir/clk at a fixed step rate.
// Define TRAKBALL_JOY_EN to let the joystick inject steps on an idle axis.
module trakball_quad_ctrl
   import trakball_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEF,
   parameter int STEP_DIV = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [24:0] ps2_mouse,
   input  logic        flip,
   input  logic        pause,
   input  logic [3:0]  joy_dir,
   output logic [3:0]  trakdata,
   output logic        busy,
   output logic        sat_pulse
);
   localparam int            PW         = $clog2(STEP_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

   trak_state_t   state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tog_q, tog_d, busy_q, busy_d, sat_q, sat_d;
   logic          tick, pkt;
   delta_t        dx, dy;
   logic          x_dir, x_clk, y_dir, y_clk, x_nz, y_nz, x_sat, y_sat;

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tog_d   = tog_q;
      tick    = 1'b0;
      pkt     = 1'b0;
      case (state_q)
         INIT: begin
            tog_d   = ps2_mouse[24];
            state_d = RUN;
         end
         RUN: begin
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               tick    = 1'b1;
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if (pause) state_d = HOLD;
         end
         HOLD: if (!pause) state_d = RUN;
         default: state_d = INIT;
      endcase
      // Packets are still taken while paused; only the step clock stops
      if (state_q != INIT && ps2_mouse[24] != tog_q) begin
         pkt   = 1'b1;
         tog_d = ps2_mouse[24];
      end

      dx = delta_t'($signed({ps2_mouse[4], ps2_mouse[15:8]}));
      dy = delta_t'($signed({ps2_mouse[5], ps2_mouse[23:16]}));
      if (flip) begin
         dx = -dx;
         dy = -dy;
      end
      busy_d = x_nz | y_nz;
      sat_d  = x_sat | y_sat;
   end

`ifdef TRAKBALL_JOY_EN
   logic jx_vld, jx_dir, jy_vld, jy_dir, unused_ps2;
   assign jx_vld     = joy_dir[1] ^ joy_dir[0];
   assign jx_dir     = joy_dir[0] ^ flip;
   assign jy_vld     = joy_dir[3] ^ joy_dir[2];
   assign jy_dir     = joy_dir[3] ^ flip;
   assign unused_ps2 = ^{ps2_mouse[7:6], ps2_mouse[3:0]};
`else
   logic unused_in;
   assign unused_in = ^{joy_dir, ps2_mouse[7:6], ps2_mouse[3:0]};
`endif

   trakball_axis #(.ACC_W(ACC_W)) u_ax_x (
      .clk(clk_sys), .rst_n(reset_n), .tick(tick), .dv(pkt), .delta(dx),
`ifdef TRAKBALL_JOY_EN
      .joy_vld(jx_vld), .joy_dir(jx_dir),
`endif
      .dir(x_dir), .sclk(x_clk), .nz_next(x_nz), .sat(x_sat)
   );

   trakball_axis #(.ACC_W(ACC_W)) u_ax_y (
      .clk(clk_sys), .rst_n(reset_n), .tick(tick), .dv(pkt), .delta(dy),
`ifdef TRAKBALL_JOY_EN
      .joy_vld(jy_vld), .joy_dir(jy_dir),
`endif
      .dir(y_dir), .sclk(y_clk), .nz_next(y_nz), .sat(y_sat)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
         presc_q <= '0;
         tog_q   <= 1'b0;
         busy_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tog_q   <= tog_d;
         busy_q  <= busy_d;
         sat_q   <= sat_d;
      end
   end

   assign trakdata[TD_XDIR] = x_dir;
   assign trakdata[TD_XCLK] = x_clk;
   assign trakdata[TD_YDIR] = y_dir;
   assign trakdata[TD_YCLK] = y_clk;
   assign busy      = busy_q;
   assign sat_pulse = sat_q;

endmodule

// File: tb/tb_trakball_quad_ctrl.sv
// Bench for trakball_quad_ctrl: directed scenarios plus random traffic against an integer reference model.
module tb_trakball_quad_ctrl;
   localparam int ACC_W = 12;
   localparam int SD    = 4;
   localparam int LIM   = 2047;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [24:0] ps2_mouse = '0;
   logic        flip = 1'b0;
   logic        pause = 1'b0;
   logic [3:0]  joy_dir = '0;
   logic [3:0]  trakdata;
   logic        busy, sat_pulse;

   int n_vec = 0;
   int n_err = 0;

   trakball_quad_ctrl #(.ACC_W(ACC_W), .STEP_DIV(SD)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_mouse(ps2_mouse), .flip(flip),
      .pause(pause), .joy_dir(joy_dir), .trakdata(trakdata), .busy(busy),
      .sat_pulse(sat_pulse)
   );

   always #5 clk_sys = ~clk_sys;

   // ---------------- reference model (0=init, 1=run, 2=hold) ----------------
   int m_state, m_presc, m_ax, m_ay;
   bit m_tog, m_xdir, m_xclk, m_ydir, m_yclk, m_busy, m_sat;
   int c_dx, c_dy, c_nx, c_ny;
   bit c_tick, c_acc, c_satx, c_saty, c_jx, c_jy, c_jxd, c_jyd;
   logic [3:0] m_td;

   always_comb begin
      c_tick = (m_state == 1) && (m_presc == SD - 1);
      c_acc  = (m_state != 0) && (ps2_mouse[24] != m_tog);
      c_dx   = ps2_mouse[4] ? int'(ps2_mouse[15:8]) - 256 : int'(ps2_mouse[15:8]);
      c_dy   = ps2_mouse[5] ? int'(ps2_mouse[23:16]) - 256 : int'(ps2_mouse[23:16]);
      if (flip) begin
         c_dx = -c_dx;
         c_dy = -c_dy;
      end
      c_nx = m_ax - ((c_tick && m_ax != 0) ? ((m_ax > 0) ? 1 : -1) : 0) + (c_acc ? c_dx : 0);
      c_ny = m_ay - ((c_tick && m_ay != 0) ? ((m_ay > 0) ? 1 : -1) : 0) + (c_acc ? c_dy : 0);
      c_satx = (c_nx > LIM) || (c_nx < -LIM);
      c_saty = (c_ny > LIM) || (c_ny < -LIM);
      if (c_nx > LIM) c_nx = LIM; else if (c_nx < -LIM) c_nx = -LIM;
      if (c_ny > LIM) c_ny = LIM; else if (c_ny < -LIM) c_ny = -LIM;
      c_jx = 1'b0; c_jy = 1'b0; c_jxd = 1'b0; c_jyd = 1'b0;
`ifdef TRAKBALL_JOY_EN
      c_jx  = (joy_dir[1:0] == 2'b01) || (joy_dir[1:0] == 2'b10);
      c_jy  = (joy_dir[3:2] == 2'b01) || (joy_dir[3:2] == 2'b10);
      c_jxd = joy_dir[0] ^ flip;
      c_jyd = joy_dir[3] ^ flip;
`endif
      m_td = {m_xdir, m_xclk, m_ydir, m_yclk};
   end

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         m_state <= 0; m_presc <= 0; m_ax <= 0; m_ay <= 0; m_tog <= 0;
         m_xdir <= 0; m_xclk <= 0; m_ydir <= 0; m_yclk <= 0; m_busy <= 0; m_sat <= 0;
      end else begin
         m_state <= (m_state == 0) ? 1 : (pause ? 2 : 1);
         m_tog   <= ps2_mouse[24];
         if (m_state == 1) m_presc <= (m_presc + 1) % SD;
         m_ax <= c_nx;
         m_ay <= c_ny;
         if (c_tick && m_ax != 0) begin m_xdir <= (m_ax > 0); m_xclk <= !m_xclk; end
         else if (c_tick && c_jx) begin m_xdir <= c_jxd; m_xclk <= !m_xclk; end
         if (c_tick && m_ay != 0) begin m_ydir <= (m_ay > 0); m_yclk <= !m_yclk; end
         else if (c_tick && c_jy) begin m_ydir <= c_jyd; m_yclk <= !m_yclk; end
         m_busy <= (c_nx != 0) || (c_ny != 0);
         m_sat  <= c_satx || c_saty;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk_sys);
      reset_n = 1'b0;
      #2;
      @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   task automatic send(input logic [7:0] xb, input logic xs, input logic [7:0] yb, input logic ys);
      ps2_mouse[15:8]  = xb;
      ps2_mouse[4]     = xs;
      ps2_mouse[23:16] = yb;
      ps2_mouse[5]     = ys;
      ps2_mouse[24]    = ~ps2_mouse[24];
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ps2_mouse[24] = 1'b1;
      do_reset();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_sys);
         n_vec++;
         if ({trakdata, busy, sat_pulse} !== 6'b0)
            begin n_err++; $display("FAIL reset_idle c=%0d: got td=%b busy=%b sat=%b want 0000/0/0", c, trakdata, busy, sat_pulse); end
      end
   endtask

   task automatic test_pos_x();
      int tog = 0, last = 0;
      logic prev;
      do_reset();
      flip = 0; pause = 0; joy_dir = '0;
      @(negedge clk_sys);
      prev = trakdata[2];
      send(8'd3, 1'b0, 8'd0, 1'b0);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk_sys);
         if (trakdata[2] !== prev) begin
            tog++;
            prev = trakdata[2];
            n_vec++;
            if (trakdata[3] !== 1'b1) begin n_err++; $display("FAIL posx_dir: got %b want 1", trakdata[3]); end
            n_vec++;
            if (tog == 1) begin
               if (c > SD + 2) begin n_err++; $display("FAIL posx_first_step: got %0d cycles want <= %0d", c, SD + 2); end
            end else if (c - last != SD) begin
               n_err++; $display("FAIL posx_interval: got %0d want %0d", c - last, SD);
            end
            last = c;
         end
      end
      n_vec++;
      if (tog != 3) begin n_err++; $display("FAIL posx_toggles: got %0d want 3", tog); end
      n_vec++;
      if ({trakdata, busy} !== 5'b1100_0) begin n_err++; $display("FAIL posx_final: got td=%b busy=%b want 1100/0", trakdata, busy); end
   endtask

   task automatic test_neg_y_flip();
      for (int f = 0; f < 2; f++) begin
         int tog = 0;
         logic prev;
         flip = f[0];
         @(negedge clk_sys);
         prev = trakdata[0];
         send(8'd0, 1'b0, 8'hFE, 1'b1);
         for (int c = 0; c < 40; c++) begin
            @(negedge clk_sys);
            if (trakdata[0] !== prev) begin
               tog++;
               prev = trakdata[0];
               n_vec++;
               if (trakdata[1] !== f[0]) begin n_err++; $display("FAIL negy_dir flip=%0d: got %b want %b", f, trakdata[1], f[0]); end
            end
         end
         n_vec++;
         if (tog != 2) begin n_err++; $display("FAIL negy_toggles flip=%0d: got %0d want 2", f, tog); end
      end
      flip = 0;
   endtask

   task automatic test_saturation();
      int tog = 0, expv;
      bit done = 0;
      logic prev;
      do_reset();
      pause = 1;
      repeat (2) @(negedge clk_sys);
      for (int i = 1; i <= 9; i++) begin
         send(8'd255, 1'b0, 8'd0, 1'b0);
         @(negedge clk_sys);
         expv = (255 * i > LIM) ? LIM : 255 * i;
         n_vec++;
         if (dut.u_ax_x.acc_q !== 12'(expv)) begin n_err++; $display("FAIL sat_acc i=%0d: got %0d want %0d", i, dut.u_ax_x.acc_q, expv); end
         n_vec++;
         if (sat_pulse !== (i == 9)) begin n_err++; $display("FAIL sat_pulse i=%0d: got %b want %b", i, sat_pulse, i == 9); end
         @(negedge clk_sys);
         n_vec++;
         if (sat_pulse !== 1'b0) begin n_err++; $display("FAIL sat_pulse_width i=%0d: got %b want 0", i, sat_pulse); end
      end
      prev = trakdata[2];
      pause = 0;
      for (int c = 0; c < LIM * SD + 100; c++) begin
         @(negedge clk_sys);
         if (trakdata[2] !== prev) begin tog++; prev = trakdata[2]; end
         if (!busy) begin done = 1; break; end
      end
      n_vec++;
      if (!done) begin n_err++; $display("FAIL sat_drain_timeout: busy still %b after budget", busy); end
      repeat (20) begin
         @(negedge clk_sys);
         if (trakdata[2] !== prev) begin tog++; prev = trakdata[2]; end
      end
      n_vec++;
      if (tog != LIM) begin n_err++; $display("FAIL sat_toggles: got %0d want %0d", tog, LIM); end
   endtask

   task automatic test_pause_mid();
      int tx = 0, ty = 0;
      logic px, py;
      logic [3:0] td;
      logic [$clog2(SD)-1:0] ps;
      do_reset();
      pause = 0; flip = 0;
      @(negedge clk_sys);
      px = trakdata[2]; py = trakdata[0];
      send(8'd10, 1'b0, 8'd5, 1'b0);
      for (int c = 0; c < 14; c++) begin
         if (c == 13) pause = 1;
         @(negedge clk_sys);
         if (trakdata[2] !== px) begin tx++; px = trakdata[2]; end
         if (trakdata[0] !== py) begin ty++; py = trakdata[0]; end
      end
      td = trakdata;
      ps = dut.presc_q;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_sys);
         n_vec++;
         if (trakdata !== td || dut.presc_q !== ps)
            begin n_err++; $display("FAIL pause_frozen c=%0d: got td=%b presc=%0d want td=%b presc=%0d", c, trakdata, dut.presc_q, td, ps); end
      end
      pause = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk_sys);
         if (trakdata[2] !== px) begin tx++; px = trakdata[2]; end
         if (trakdata[0] !== py) begin ty++; py = trakdata[0]; end
      end
      n_vec++;
      if (tx != 10) begin n_err++; $display("FAIL pause_x_toggles: got %0d want 10", tx); end
      n_vec++;
      if (ty != 5) begin n_err++; $display("FAIL pause_y_toggles: got %0d want 5", ty); end
      // asynchronous reset in the middle of a drain
      send(8'd20, 1'b0, 8'd20, 1'b0);
      repeat (15) @(negedge clk_sys);
      #2 reset_n = 1'b0;
      #1;
      n_vec++;
      if ({trakdata, busy, sat_pulse} !== 6'b0 || dut.u_ax_x.acc_q !== 12'd0 || dut.u_ax_y.acc_q !== 12'd0)
         begin n_err++; $display("FAIL reset_mid_drain: got td=%b busy=%b accx=%0d accy=%0d want all 0", trakdata, busy, dut.u_ax_x.acc_q, dut.u_ax_y.acc_q); end
      @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] xb, yb;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk_sys);
         n_vec++;
         if ({trakdata, busy, sat_pulse} !== {m_td, m_busy, m_sat})
            begin n_err++; $display("FAIL rand_cmp c=%0d: got td=%b busy=%b sat=%b want td=%b busy=%b sat=%b", c, trakdata, busy, sat_pulse, m_td, m_busy, m_sat); end
         if ($urandom_range(0, 9) == 0) begin
            xb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            yb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            send(xb, 1'($urandom), yb, 1'($urandom));
         end
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         if ($urandom_range(0, 99) == 0) flip = ~flip;
`ifdef TRAKBALL_JOY_EN
         if ($urandom_range(0, 49) == 0) joy_dir = 4'($urandom);
`endif
      end
      pause = 0; flip = 0; joy_dir = '0;
   endtask

`ifdef TRAKBALL_JOY_EN
   task automatic test_joy();
      int tog = 0, neg = 0;
      logic prev;
      do_reset();
      flip = 0; pause = 0; joy_dir = 4'b0001;
      @(negedge clk_sys);
      prev = trakdata[2];
      for (int c = 0; c < 41; c++) begin
         @(negedge clk_sys);
         if (trakdata[2] !== prev) begin
            tog++; prev = trakdata[2];
            n_vec++;
            if (trakdata[3] !== 1'b1) begin n_err++; $display("FAIL joy_right_dir: got %b want 1", trakdata[3]); end
         end
      end
      n_vec++;
      if (tog < 9) begin n_err++; $display("FAIL joy_right_steps: got %0d want >= 9", tog); end
      send(8'hFF, 1'b1, 8'd0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_sys);
         n_vec++;
         if (trakdata !== m_td) begin n_err++; $display("FAIL joy_pkt_cmp c=%0d: got %b want %b", c, trakdata, m_td); end
         if (trakdata[2] !== prev) begin
            prev = trakdata[2];
            if (trakdata[3] == 1'b0) neg++;
         end
      end
      n_vec++;
      if (neg != 1) begin n_err++; $display("FAIL joy_pkt_steps: got %0d dir-0 steps want 1", neg); end
      joy_dir = 4'b0011;
      @(negedge clk_sys);
      prev = trakdata[2];
      tog = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_sys);
         if (trakdata[2] !== prev) begin tog++; prev = trakdata[2]; end
      end
      n_vec++;
      if (tog != 0) begin n_err++; $display("FAIL joy_opposed: got %0d toggles want 0", tog); end
      joy_dir = '0;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_pos_x();
      test_neg_y_flip();
      test_saturation();
      test_pause_mid();
`ifdef TRAKBALL_JOY_EN
      test_joy();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
